dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the CPU load/store path and the image DMA engine. It sits directly in front of the data memory's `we`/`addr`/`wd`/`rd` port. It grants at most one access per cycle, bounds starvation with a run-length limit, and returns registered read data to each requester one cycle after its grant.

## Interface
- `MAX_RUN`, default 4: maximum consecutive contested grants to the current owner before ownership passes to the other requester (≥1).
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `c_req`  in  1  CPU access request, level, held until `c_gnt`.
- `c_we`  in  1  CPU write (1) / read (0).
- `c_addr`  in  AW  CPU byte/word address, passed unchanged.
- `c_wd`  in  DW  CPU write data.
- `c_gnt`  out  1  combinational: CPU access performed this cycle.
- `c_rvalid`  out  1  registered: `c_rd` holds data for the CPU read granted last cycle.
- `c_rd`  out  DW  registered CPU read data, held until next CPU read grant.
- `d_req`, `d_we`, `d_addr`, `d_wd`, `d_gnt`, `d_rvalid`, `d_rd`: identical set for the DMA requester.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  AW  memory address.
- `m_wd`  out  DW  memory write data.
- `m_rd`  in  DW  memory read data, combinational from `m_addr`.
- `owner`  out  1  registered current owner (0 = CPU, 1 = DMA).

## Operation
- State: `owner` (1 bit) and run counter `cnt` (range 0..MAX_RUN).
- Grant decision is combinational from `c_req`, `d_req`, `owner` and `cnt`:
  - No request: no grant. `m_we`=0, `m_addr`=0, `m_wd`=0. `cnt`<=0; `owner` holds.
  - Only X requests (uncontested): grant X. `owner`<=X, `cnt`<=1.
  - Both request, `cnt` < MAX_RUN: grant `owner`. `cnt`<=`cnt`+1.
  - Both request, `cnt` == MAX_RUN: grant the other requester. `owner`<=other, `cnt`<=1.
- Effect: under continuous contention the owner gets MAX_RUN grants, then the other requester gets MAX_RUN grants, alternating.
- Memory mux: `m_addr`/`m_wd` come from the granted requester. `m_we` = granted requester's `we` AND grant.
- Exactly one of `c_gnt`/`d_gnt` is high in a granted cycle; never both.
- Read return: on a rising edge ending a cycle in which X had a read grant, `X_rd`<=`m_rd` and `X_rvalid`<=1. Otherwise `X_rvalid`<=0 and `X_rd` holds.
- A write grant never produces `rvalid`.
- Addresses are not range-checked. Out-of-map accesses are granted normally; the memory returns 0.

## Timing
- Grant latency 0 cycles: `gnt` is asserted in the same cycle as `req` when arbitration favours the requester.
- Writes commit in the grant cycle; the memory captures on the falling edge inside it.
- Read data latency 1 cycle: `rvalid`/`rd` are valid in cycle N+1 for a grant in cycle N.
- Back-to-back reads by one requester give `rvalid` high on consecutive cycles.
- Reset (`rst_n`=0 at a rising edge):
  - `owner`=0, `cnt`=0, `c_rvalid`=`d_rvalid`=0, `c_rd`=`d_rd`=0.
  - While `rst_n`=0, `c_gnt`=`d_gnt`=0 and `m_we`=0 regardless of requests.
- Reset mid-run discards any pending `rvalid` and restarts arbitration with the CPU as owner.
- Simultaneous first requests after reset or idle: `owner` holds its previous value, so the owner wins; after reset that is the CPU.
- Requester dropping `req` mid-run: the next cycle is uncontested, so `cnt` restarts at 1.
- `cnt` never exceeds MAX_RUN. MAX_RUN=1 gives strict alternation under contention.

## Test plan
- Reset: hold `rst_n`=0 with `c_req`=`d_req`=1 and `c_we`=1 -> `m_we`=0, no grants, `owner`=0, `c_rvalid`=`d_rvalid`=0, `c_rd`=0.
- CPU read alone: `c_req`=1, `c_we`=0, `c_addr`=152100, memory returns 0xDEADBEEF -> `c_gnt`=1 in the same cycle, `m_addr`=152100; next cycle `c_rvalid`=1, `c_rd`=0xDEADBEEF, `d_rvalid`=0.
- DMA write alone: `d_req`=1, `d_we`=1, `d_addr`=150000, `d_wd`=0x5A -> `d_gnt`=1, `m_we`=1, `m_addr`=150000, `m_wd`=0x5A; `owner`=1 next cycle; no `rvalid`.
- Contention, MAX_RUN=4: both requesting continuously from reset -> grant sequence C,C,C,C,D,D,D,D,C… ; `c_gnt` and `d_gnt` never both 1.
- Dropout: `owner`=CPU with `cnt`=3, both requesting; CPU drops `req` for one cycle, then re-asserts -> DMA granted uncontested (`cnt`=1, `owner`=1), then DMA gets 3 more contested grants before CPU.
- Reset mid-run: assert `rst_n`=0 for one cycle during a DMA read grant -> no `d_rvalid` the following cycle, `owner`=0, and the first contested cycle after release grants the CPU.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU
// load/store path and the image DMA engine. One access per cycle, with a
// run-length limit so neither requester can starve the other.
//
// Handshake: X_req is a level held until X_gnt; the access happens in the
// cycle where X_req && X_gnt are both high (gnt is combinational, zero
// latency). For a read, X_rvalid pulses for exactly one cycle on the next
// cycle and X_rd carries the data, holding it until the next read grant.
module dmem_arbiter #(
  parameter int MAX_RUN = 4,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wd,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rd,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wd,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rd,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wd,
  input  logic [DW-1:0] m_rd,
  output logic          owner
);

  localparam int            CW      = $clog2(MAX_RUN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_RUN);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          c_rvalid_q, c_rvalid_d;
  logic          d_rvalid_q, d_rvalid_d;
  logic [DW-1:0] c_rd_q, c_rd_d;
  logic [DW-1:0] d_rd_q, d_rd_d;

  // Grant decision and next owner/run count; nothing is granted in reset.
  always_comb begin
    c_gnt   = 1'b0;
    d_gnt   = 1'b0;
    owner_d = owner_q;
    cnt_d   = '0;
    if (!rst_n) begin
      owner_d = 1'b0;
    end else if (c_req && d_req) begin
      if (cnt_q < MAX_CNT) begin
        // Owner keeps the memory while its run is not exhausted.
        c_gnt = ~owner_q;
        d_gnt = owner_q;
        cnt_d = cnt_q + ONE;
      end else begin
        // Run exhausted: hand over and start the other side's run.
        c_gnt   = owner_q;
        d_gnt   = ~owner_q;
        owner_d = ~owner_q;
        cnt_d   = ONE;
      end
    end else if (c_req) begin
      c_gnt   = 1'b1;
      owner_d = 1'b0;
      cnt_d   = ONE;
    end else if (d_req) begin
      d_gnt   = 1'b1;
      owner_d = 1'b1;
      cnt_d   = ONE;
    end
  end

  // Memory port mux: idle cycles drive zeros so the bus is quiet.
  always_comb begin
    m_we   = 1'b0;
    m_addr = '0;
    m_wd   = '0;
    if (c_gnt) begin
      m_we   = c_we;
      m_addr = c_addr;
      m_wd   = c_wd;
    end else if (d_gnt) begin
      m_we   = d_we;
      m_addr = d_addr;
      m_wd   = d_wd;
    end
  end

  // Read return: capture m_rd for a read granted this cycle, else hold data.
  always_comb begin
    c_rvalid_d = c_gnt & ~c_we;
    d_rvalid_d = d_gnt & ~d_we;
    c_rd_d     = c_rvalid_d ? m_rd : c_rd_q;
    d_rd_d     = d_rvalid_d ? m_rd : d_rd_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q    <= 1'b0;
      cnt_q      <= '0;
      c_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      c_rd_q     <= '0;
      d_rd_q     <= '0;
    end else begin
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      c_rvalid_q <= c_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      c_rd_q     <= c_rd_d;
      d_rd_q     <= d_rd_d;
    end
  end

  assign owner    = owner_q;
  assign c_rvalid = c_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign c_rd     = c_rd_q;
  assign d_rd     = d_rd_q;

endmodule
